// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle for mul_share_arbiter, plus the operand/product link
// to the shared multiplier.
interface mul_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_p;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_data;
    logic              rsp_ready;
    logic [15:0]       op_count;

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, op_count
    );

    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, op_count
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin time-sharing of one combinational multiplier among NREQ requesters;
// one operation in flight, product returned with the owning requester index.
module mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic clk,
    input  logic rst,
    mul_share_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  id_reg;
    logic [IDW-1:0]  grant_idx;
    logic [IDW:0]    cand;
    logic            grant_found;
    logic            accept;
    logic [NREQ-1:0] ready_vec;
    logic [W-1:0]    a_arr [NREQ];
    logic [W-1:0]    b_arr [NREQ];

    logic [W-1:0]    mul_a_reg;
    logic [W-1:0]    mul_b_reg;
    logic            rsp_valid_reg;
    logic [IDW-1:0]  rsp_id_reg;
    logic [2*W-1:0]  rsp_data_reg;
    logic [15:0]     op_count_reg;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = bus.req_a[gi*W +: W];
        assign b_arr[gi] = bus.req_b[gi*W +: W];
    end

    // Walk offsets from farthest to nearest so the requester closest after ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = {1'b0, ptr_reg} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (bus.req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_vec = '0;
        if (!rst && state_reg == IDLE && grant_found) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    assign accept = |(bus.req_valid & ready_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= IDW'(NREQ - 1);
            id_reg        <= '0;
            mul_a_reg     <= '0;
            mul_b_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
            op_count_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        mul_a_reg <= a_arr[grant_idx];
                        mul_b_reg <= b_arr[grant_idx];
                        id_reg    <= grant_idx;
                        ptr_reg   <= grant_idx;
                    end
                end
                EXEC: begin
                    rsp_data_reg  <= bus.mul_p;
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        op_count_reg  <= op_count_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.mul_a     = mul_a_reg;
    assign bus.mul_b     = mul_b_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.op_count  = op_count_reg;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scenario bench for mul_share_arbiter: grants and expected products are queued
// at request handshakes and matched against responses as they complete.
module tb_mul_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;
    localparam int SBW  = IDW + 2*W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    mul_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural stand-in for the shared multiplier.
    assign bus.mul_p = (2*W)'(bus.mul_a) * (2*W)'(bus.mul_b);

    logic [W-1:0] a_op [NREQ];
    logic [W-1:0] b_op [NREQ];
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
        assign bus.req_a[gi*W +: W] = a_op[gi];
        assign bus.req_b[gi*W +: W] = b_op[gi];
    end

    int n_checks = 0;
    int n_fail   = 0;

    int             grant_q [$];
    logic [SBW-1:0] exp_q   [$];
    logic [SBW-1:0] rsp_q   [$];

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    logic [2*W-1:0] prod;
                    prod = (2*W)'(a_op[i]) * (2*W)'(b_op[i]);
                    grant_q.push_back(i);
                    exp_q.push_back({IDW'(i), prod});
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_q.push_back({bus.rsp_id, bus.rsp_data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_queues();
        grant_q.delete();
        exp_q.delete();
        rsp_q.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        clear_queues();
    endtask

    task automatic wait_counts(input int ng, input int nr, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            sample();
            if (grant_q.size() >= ng && rsp_q.size() >= nr) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        sample();
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
        n_checks++; if (bus.rsp_data !== 8'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %0d expected 0", bus.rsp_data); end
        n_checks++; if (bus.op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d expected 0", bus.op_count); end
        n_checks++; if (bus.mul_a !== 4'd0 || bus.mul_b !== 4'd0) begin n_fail++; $display("FAIL reset_mul_ops: got %0d,%0d expected 0,0", bus.mul_a, bus.mul_b); end
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        clear_queues();
    endtask

    task automatic test_single();
        a_op[0] = 4'd3;
        b_op[0] = 4'd5;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0001;
        sample();
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        sample();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_exec_valid: got %b expected 0", bus.rsp_valid); end
        tick();
        sample();
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id: got %0d expected 0", bus.rsp_id); end
        n_checks++; if (bus.rsp_data !== 8'd15) begin n_fail++; $display("FAIL single_rsp_data: got %0d expected 15", bus.rsp_data); end
        n_checks++; if (bus.op_count !== 16'd0) begin n_fail++; $display("FAIL single_count_before: got %0d expected 0", bus.op_count); end
        tick();
        sample();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_done: got %b expected 0", bus.rsp_valid); end
        n_checks++; if (bus.op_count !== 16'd1) begin n_fail++; $display("FAIL single_count_after: got %0d expected 1", bus.op_count); end
        n_checks++; if (rsp_q.size() != 1) begin n_fail++; $display("FAIL single_rsp_count: got %0d expected 1", rsp_q.size()); end
        while (rsp_q.size() > 0 && exp_q.size() > 0) begin
            logic [SBW-1:0] e, r;
            e = exp_q.pop_front();
            r = rsp_q.pop_front();
            $display("single: rsp id=%0d data=%0d", r[SBW-1:2*W], r[2*W-1:0]);
            n_checks++; if (r !== e) begin n_fail++; $display("FAIL single_sb: got %h expected %h", r, e); end
        end
    endtask

    task automatic test_round_robin();
        int exp_grant [5] = '{0, 1, 2, 3, 0};
        int exp_data  [5] = '{2, 4, 6, 8, 2};
        bit ok;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_op[i] = W'(i + 1);
            b_op[i] = 4'd2;
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        wait_counts(5, 0, 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_grant_timeout: got %0d grants expected 5", grant_q.size()); end
        tick();
        bus.req_valid = '0;
        wait_counts(5, 5, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_rsp_timeout: got %0d responses expected 5", rsp_q.size()); end
        for (int i = 0; i < 5 && i < grant_q.size(); i++) begin
            n_checks++; if (grant_q[i] != exp_grant[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, grant_q[i], exp_grant[i]); end
        end
        for (int i = 0; i < 5 && rsp_q.size() > 0 && exp_q.size() > 0; i++) begin
            logic [SBW-1:0] e, r;
            e = exp_q.pop_front();
            r = rsp_q.pop_front();
            $display("rr: rsp id=%0d data=%0d", r[SBW-1:2*W], r[2*W-1:0]);
            n_checks++; if (r !== e) begin n_fail++; $display("FAIL rr_sb[%0d]: got %h expected %h", i, r, e); end
            n_checks++; if (int'(r[2*W-1:0]) != exp_data[i]) begin n_fail++; $display("FAIL rr_data[%0d]: got %0d expected %0d", i, r[2*W-1:0], exp_data[i]); end
        end
    endtask

    task automatic test_pair();
        int exp_grant [4] = '{0, 2, 0, 2};
        bit ok;
        apply_reset();
        a_op[0] = 4'd7;  b_op[0] = 4'd9;
        a_op[2] = 4'd11; b_op[2] = 4'd13;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0101;
        wait_counts(4, 0, 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pair_grant_timeout: got %0d grants expected 4", grant_q.size()); end
        tick();
        bus.req_valid = '0;
        wait_counts(4, 4, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pair_rsp_timeout: got %0d responses expected 4", rsp_q.size()); end
        for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
            n_checks++; if (grant_q[i] != exp_grant[i]) begin n_fail++; $display("FAIL pair_grant[%0d]: got %0d expected %0d", i, grant_q[i], exp_grant[i]); end
        end
        while (rsp_q.size() > 0 && exp_q.size() > 0) begin
            logic [SBW-1:0] e, r;
            e = exp_q.pop_front();
            r = rsp_q.pop_front();
            $display("pair: rsp id=%0d data=%0d", r[SBW-1:2*W], r[2*W-1:0]);
            n_checks++; if (r !== e) begin n_fail++; $display("FAIL pair_sb: got %h expected %h", r, e); end
        end
    endtask

    task automatic test_max_operands();
        bit ok;
        apply_reset();
        a_op[3] = 4'd15;
        b_op[3] = 4'd15;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1000;
        wait_counts(1, 0, 10, ok);
        tick();
        bus.req_valid = '0;
        wait_counts(1, 1, 10, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL max_timeout: got %0d responses expected 1", rsp_q.size()); end
        if (rsp_q.size() > 0 && exp_q.size() > 0) begin
            logic [SBW-1:0] e, r;
            e = exp_q.pop_front();
            r = rsp_q.pop_front();
            $display("max: rsp id=%0d data=%0d", r[SBW-1:2*W], r[2*W-1:0]);
            n_checks++; if (r !== {2'd3, 8'hE1}) begin n_fail++; $display("FAIL max_rsp: got %h expected 3e1", r); end
            n_checks++; if (r !== e) begin n_fail++; $display("FAIL max_sb: got %h expected %h", r, e); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        a_op[1] = 4'd6;
        b_op[1] = 4'd7;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        sample();
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_ready: got %b expected 0010", bus.req_ready); end
        tick();
        bus.req_valid = 4'b1111;
        sample();
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_exec_ready: got %b expected 0000", bus.req_ready); end
        tick();
        for (int c = 0; c < 5; c++) begin
            sample();
            n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, bus.rsp_valid); end
            n_checks++; if (bus.rsp_data !== 8'd42) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d expected 42", c, bus.rsp_data); end
            n_checks++; if (bus.rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d expected 1", c, bus.rsp_id); end
            n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", c, bus.req_ready); end
            n_checks++; if (bus.op_count !== 16'd0) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d expected 0", c, bus.op_count); end
            tick();
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        sample();
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 1", bus.rsp_valid); end
        tick();
        sample();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done_valid: got %b expected 0", bus.rsp_valid); end
        n_checks++; if (bus.op_count !== 16'd1) begin n_fail++; $display("FAIL bp_done_count: got %0d expected 1", bus.op_count); end
        n_checks++; if (rsp_q.size() != 1) begin n_fail++; $display("FAIL bp_rsp_count: got %0d expected 1", rsp_q.size()); end
        while (rsp_q.size() > 0 && exp_q.size() > 0) begin
            logic [SBW-1:0] e, r;
            e = exp_q.pop_front();
            r = rsp_q.pop_front();
            $display("bp: rsp id=%0d data=%0d", r[SBW-1:2*W], r[2*W-1:0]);
            n_checks++; if (r !== e) begin n_fail++; $display("FAIL bp_sb: got %h expected %h", r, e); end
        end
    endtask

    task automatic test_reset_in_exec();
        bit ok;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_op[i] = W'(i + 4);
            b_op[i] = W'(6 - i);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0100;
        sample();
        n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL rexec_ready: got %b expected 0100", bus.req_ready); end
        tick();
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        tick();
        rst = 1'b0;
        clear_queues();
        sample();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rexec_valid: got %b expected 0", bus.rsp_valid); end
        n_checks++; if (bus.op_count !== 16'd0) begin n_fail++; $display("FAIL rexec_count: got %0d expected 0", bus.op_count); end
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rexec_next_grant: got %b expected 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        wait_counts(1, 1, 10, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rexec_timeout: got %0d responses expected 1", rsp_q.size()); end
        if (rsp_q.size() > 0 && exp_q.size() > 0) begin
            logic [SBW-1:0] e, r;
            e = exp_q.pop_front();
            r = rsp_q.pop_front();
            $display("rexec: rsp id=%0d data=%0d", r[SBW-1:2*W], r[2*W-1:0]);
            n_checks++; if (r !== {2'd0, 8'd24}) begin n_fail++; $display("FAIL rexec_rsp: got %h expected 018", r); end
            n_checks++; if (r !== e) begin n_fail++; $display("FAIL rexec_sb: got %h expected %h", r, e); end
        end
        for (int c = 0; c < 4; c++) tick();
        sample();
        n_checks++; if (rsp_q.size() != 0) begin n_fail++; $display("FAIL rexec_stray: got %0d extra responses expected 0", rsp_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_pair();
        test_max_operands();
        test_backpressure();
        test_reset_in_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
